// File: rtl/keypad_pkg.sv
// Keypad scanner shared types: FSM state encoding, key code constants,
// raw-index-to-code map and lowest-active-row priority pick.
package keypad_pkg;

    localparam int unsigned ROW_W   = 4;
    localparam int unsigned COL_W   = 4;
    localparam int unsigned CODE_W  = 4;
    localparam int unsigned STATE_W = 3;
    localparam int unsigned IDX_W   = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_SCAN     = 3'd0,
        ST_DEBOUNCE = 3'd1,
        ST_HELD     = 3'd2,
        ST_RELEASE  = 3'd3
    } kp_state_e;

    localparam logic [CODE_W-1:0] KEY_ADD = 4'hA;
    localparam logic [CODE_W-1:0] KEY_SUB = 4'hB;
    localparam logic [CODE_W-1:0] KEY_MUL = 4'hC;
    localparam logic [CODE_W-1:0] KEY_DIV = 4'hD;
    localparam logic [CODE_W-1:0] KEY_CLR = 4'hE;
    localparam logic [CODE_W-1:0] KEY_EQ  = 4'hF;

    // Raw index 4*row+col to calculator key code.
    function automatic logic [CODE_W-1:0] key_map(input logic [3:0] raw);
        logic [CODE_W-1:0] code;
        code = '0;
        case (raw)
            4'd0:  code = 4'h1;
            4'd1:  code = 4'h2;
            4'd2:  code = 4'h3;
            4'd3:  code = KEY_ADD;
            4'd4:  code = 4'h4;
            4'd5:  code = 4'h5;
            4'd6:  code = 4'h6;
            4'd7:  code = KEY_SUB;
            4'd8:  code = 4'h7;
            4'd9:  code = 4'h8;
            4'd10: code = 4'h9;
            4'd11: code = KEY_MUL;
            4'd12: code = KEY_CLR;
            4'd13: code = 4'h0;
            4'd14: code = KEY_EQ;
            4'd15: code = KEY_DIV;
        endcase
        return code;
    endfunction

    // Index of the lowest-numbered row reading low (active).
    function automatic logic [IDX_W-1:0] first_low(input logic [ROW_W-1:0] rows);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = ROW_W - 1; i >= 0; i--) begin
            if (!rows[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Key event handshake: scanner (master) offers key_code/key_valid/overrun,
// consumer (slave) returns key_ack.
interface keypad_scanner_if;
    import keypad_pkg::*;

    logic [CODE_W-1:0] key_code;
    logic              key_valid;
    logic              key_ack;
    logic              overrun;

    modport master (output key_code, output key_valid, output overrun, input key_ack);
    modport slave  (input key_code, input key_valid, input overrun, output key_ack);
endinterface

// File: rtl/keypad_debounce.sv
// Consecutive-match counter: restarts on mismatch or clear, flags done on
// the DEBOUNCE_CYCLES-th consecutive matching sample.
module keypad_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic match_i,
    output logic done_c
);
    localparam int unsigned CNT_W = 8;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign done_c = !clear_i && match_i && (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1));

    // Count matches; any break, clear or completion starts over.
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clear_i || !match_i || done_c) cnt_d = '0;
    end

    // Counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column scan, debounce, press/release tracking
// and a one-deep key event register with overrun flag.
// Optional macro KEYPAD_AUTOREPEAT_EN: repeat a held key after
// 16*DEBOUNCE_CYCLES cycles, then every 4*DEBOUNCE_CYCLES cycles.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV        = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 20
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [ROW_W-1:0]   kb_row,
    output logic [COL_W-1:0]   kb_col,
    output logic [STATE_W-1:0] state,
    keypad_scanner_if.master   kbus
);
    localparam int unsigned DIV_W = 8;

    logic [ROW_W-1:0]  sync1_q, sync2_q;
    kp_state_e         state_q, state_d;
    logic [IDX_W-1:0]  col_q, col_d, row_q, row_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [COL_W-1:0]  kb_col_q, kb_col_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic              valid_q, valid_d, ovr_q, ovr_d;
    logic              fsm_issue_c, rep_issue_c, issue_c;
    logic              db_clear_c, db_match_c, db_done_c, row_low_c;

    assign row_low_c = ~sync2_q[row_q];
    assign issue_c   = fsm_issue_c | rep_issue_c;

    keypad_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
        .clk     (clk),
        .reset   (reset),
        .clear_i (db_clear_c),
        .match_i (db_match_c),
        .done_c  (db_done_c)
    );

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int unsigned REP_W = 12;

    logic [REP_W-1:0] rep_q, rep_d, rep_thr_c;
    logic             rep_first_q, rep_first_d;

    assign rep_thr_c = rep_first_q ? REP_W'(16 * DEBOUNCE_CYCLES - 1)
                                   : REP_W'(4 * DEBOUNCE_CYCLES - 1);

    // Hold timer: long first interval after the press, short ones after.
    always_comb begin
        rep_d       = rep_q;
        rep_first_d = rep_first_q;
        rep_issue_c = 1'b0;
        if (state_q != ST_HELD) begin
            rep_d = '0;
            if (state_q == ST_DEBOUNCE) rep_first_d = 1'b1;
        end else if (row_low_c) begin
            if (rep_q == rep_thr_c) begin
                rep_issue_c = 1'b1;
                rep_d       = '0;
                rep_first_d = 1'b0;
            end else begin
                rep_d = rep_q + REP_W'(1);
            end
        end
    end

    // Repeat timer registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rep_q       <= '0;
            rep_first_q <= 1'b0;
        end else begin
            rep_q       <= rep_d;
            rep_first_q <= rep_first_d;
        end
    end
`else
    assign rep_issue_c = 1'b0;
`endif

    // Scan/debounce FSM next state; column drive follows the next column.
    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        div_d       = div_q;
        fsm_issue_c = 1'b0;
        db_clear_c  = 1'b1;
        db_match_c  = 1'b0;
        case (state_q)
            ST_SCAN: begin
                if (div_q == DIV_W'(SCAN_DIV - 1)) begin
                    div_d = '0;
                    if (|(~sync2_q)) begin
                        row_d   = first_low(sync2_q);
                        state_d = ST_DEBOUNCE;
                    end else begin
                        col_d = col_q + IDX_W'(1);
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            ST_DEBOUNCE: begin
                db_clear_c = 1'b0;
                db_match_c = row_low_c;
                if (!row_low_c) begin
                    state_d = ST_SCAN;
                    col_d   = col_q + IDX_W'(1);
                    div_d   = '0;
                end else if (db_done_c) begin
                    fsm_issue_c = 1'b1;
                    state_d     = ST_HELD;
                end
            end
            ST_HELD: begin
                if (!row_low_c) state_d = ST_RELEASE;
            end
            ST_RELEASE: begin
                db_clear_c = 1'b0;
                db_match_c = !row_low_c;
                if (row_low_c) begin
                    state_d = ST_HELD;
                end else if (db_done_c) begin
                    state_d = ST_SCAN;
                    col_d   = '0;
                    div_d   = '0;
                end
            end
            default: state_d = ST_SCAN;
        endcase
        kb_col_d = ~(COL_W'(1) << col_d);
    end

    // Event register: load when free or being acked, else drop and flag.
    always_comb begin
        code_d  = code_q;
        valid_d = valid_q;
        ovr_d   = 1'b0;
        if (issue_c) begin
            if (!valid_q || kbus.key_ack) begin
                code_d  = key_map({row_q, col_q});
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (kbus.key_ack) begin
            valid_d = 1'b0;
        end
    end

    // Synchronizer, FSM and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            state_q  <= ST_SCAN;
            col_q    <= '0;
            row_q    <= '0;
            div_q    <= '0;
            kb_col_q <= COL_W'(4'b1110);
            code_q   <= '0;
            valid_q  <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            sync1_q  <= kb_row;
            sync2_q  <= sync1_q;
            state_q  <= state_d;
            col_q    <= col_d;
            row_q    <= row_d;
            div_q    <= div_d;
            kb_col_q <= kb_col_d;
            code_q   <= code_d;
            valid_q  <= valid_d;
            ovr_q    <= ovr_d;
        end
    end

    assign kb_col         = kb_col_q;
    assign state          = state_q;
    assign kbus.key_code  = code_q;
    assign kbus.key_valid = valid_q;
    assign kbus.overrun   = ovr_q;
endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 4: clk cycles each column is driven; legal range 3..255.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 20: consecutive stable samples for press or release, 2 ms at 10 kHz; legal range 1..255.
REQ-003 SHALL have port clk, input, 1: single clock, the 10 kHz internal oscillator.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset; the only reset.
REQ-005 SHALL have port kb_row, input, 4: keypad rows, active-low, externally pulled up, asynchronous to clk.
REQ-006 SHALL have port kb_col, output, 4: keypad column drive, active-low one-hot.
REQ-007 SHALL have port key_code, output, 4: code of the key held in the output register.
REQ-008 SHALL have port key_valid, output, 1: key_code holds an unconsumed event.
REQ-009 SHALL have port key_ack, input, 1: consumer accepts the event.
REQ-010 SHALL have port overrun, output, 1: one-cycle pulse when an event is dropped.
REQ-011 SHALL have port state, output, 3: FSM state encoding, for debug pins.

Function
REQ-012 SHALL pass kb_row through a 2-flop synchronizer before any use.
REQ-013 SHALL implement states SCAN=0, DEBOUNCE=1, HELD=2, RELEASE=3.
REQ-014 In SCAN: kb_col SHALL drive column c low for SCAN_DIV cycles, then advance c from 3 back to 0; synchronized rows SHALL be sampled only on the last dwell cycle.
REQ-015 SCAN sample with any row low SHALL latch the lowest-index low row r and hold column c, then go to DEBOUNCE; other keys are ignored until return to SCAN.
REQ-016 In DEBOUNCE: DEBOUNCE_CYCLES consecutive samples with row r low SHALL issue the event and go to HELD; any sample with row r high SHALL return to SCAN at column c+1.
REQ-017 Key code mapping: raw index 4*r+c SHALL map to rows 1 2 3 A / 4 5 6 B / 7 8 9 C / E 0 F D (hex codes; A=add, B=sub, C=mul, D=div, E=clear, F=equals).
REQ-018 Issue with key_valid=0, or key_valid=1 and key_ack=1 in the same cycle: key_code SHALL load and key_valid SHALL be 1 on the next cycle.
REQ-019 Issue with key_valid=1 and key_ack=0: the new event SHALL be dropped; key_code SHALL be unchanged; overrun SHALL pulse for 1 cycle.
REQ-020 key_ack with no issue SHALL clear key_valid next cycle; key_ack while key_valid=0 SHALL be ignored.
REQ-021 In HELD: a row r high sample SHALL go to RELEASE.
REQ-022 In RELEASE: DEBOUNCE_CYCLES consecutive samples with row r high SHALL go to SCAN at column 0; a row r low sample SHALL return to HELD with no new event.
REQ-023 Latency from the first stable low synchronized sample to key_valid SHALL be DEBOUNCE_CYCLES+1 cycles.

Reset
REQ-024 Reset SHALL asynchronously force: state=SCAN, column 0, kb_col=4'b1110, key_code=0, key_valid=0, overrun=0, synchronizer and counters 0.
REQ-025 Reset mid-DEBOUNCE, HELD or RELEASE SHALL discard the pending key and issue no event after release of reset.

Configuration
REQ-026 With KEYPAD_AUTOREPEAT_EN defined: in HELD, the held key SHALL re-issue after 16*DEBOUNCE_CYCLES cycles, then every 4*DEBOUNCE_CYCLES cycles, under REQ-018/019 rules.
REQ-027 Without KEYPAD_AUTOREPEAT_EN: exactly one event per press; no repeat counter logic is present.

Structure
REQ-028 Package keypad_pkg SHALL hold the state encoding, key code constants (KEY_ADD, KEY_SUB, KEY_MUL, KEY_DIV, KEY_CLR, KEY_EQ) and the raw-index-to-code map.
REQ-029 Sub-module keypad_debounce SHALL hold the stable-sample counter: restarts on mismatch, flags done at DEBOUNCE_CYCLES.

Verification (SCAN_DIV=4, DEBOUNCE_CYCLES=8)
REQ-030 Press row 1 at column 2, hold 50 cycles, release -> one event key_code=6, key_valid=1 until key_ack, state returns to 0.
REQ-031 Glitch row 0 low for 3 cycles on column 0 -> DEBOUNCE then SCAN, no key_valid, no overrun.
REQ-032 Press row 3 at column 1 while key_valid=1 holding 5, no ack -> key_code stays 5, overrun pulses once.
REQ-033 Keys (0,0) and (2,0) pressed together -> only key_code=1; (2,0) ignored until full release.
REQ-034 Assert reset in HELD with key_valid=1 -> key_valid=0, kb_col=4'b1110 immediately; no event after reset while key held then released.
REQ-035 With KEYPAD_AUTOREPEAT_EN, hold key 0 for 300 cycles acking each event -> first repeat 128 cycles after the first event, then every 32 cycles.
